// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle from ID through the ID/EX,
// EX/MEM and MEM/WB pipeline registers and exposes each stage's fields.
// It also resolves the EX destination register, raises a load-use stall,
// and turns stalled or flushed ID instructions into bubbles.
// Bundle layout: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite,
// [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
module ctrl_pipe #(
   parameter int CTRL_W = 8,
   parameter int REG_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [REG_W-1:0]  rs_i,
   input  logic [REG_W-1:0]  rt_i,
   input  logic [REG_W-1:0]  rd_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              ex_alusrc_o,
   output logic [1:0]        ex_aluop_o,
   output logic [REG_W-1:0]  ex_wreg_o,
   output logic              mem_memread_o,
   output logic              mem_memwrite_o,
   output logic              mem_regwrite_o,
   output logic [REG_W-1:0]  mem_wreg_o,
   output logic              wb_regwrite_o,
   output logic              wb_memtoreg_o,
   output logic [REG_W-1:0]  wb_wreg_o
);

   localparam int BitRegWrite = 7;
   localparam int BitMemtoReg = 6;
   localparam int BitMemRead  = 5;
   localparam int BitMemWrite = 4;
   localparam int BitAluSrc   = 3;
   localparam int BitAluOpHi  = 2;
   localparam int BitAluOpLo  = 1;
   localparam int BitRegDst   = 0;

   // ID/EX stage register
   logic [CTRL_W-1:0] idExCtrl;
   logic [REG_W-1:0]  idExRt;
   logic [REG_W-1:0]  idExRd;

   // EX/MEM stage register
   logic              exMemRegWrite;
   logic              exMemMemtoReg;
   logic              exMemMemRead;
   logic              exMemMemWrite;
   logic [REG_W-1:0]  exMemWreg;

   // MEM/WB stage register
   logic              memWbRegWrite;
   logic              memWbMemtoReg;
   logic [REG_W-1:0]  memWbWreg;

   logic [REG_W-1:0]  exWreg;
   logic              exWritesReg;
   logic              loadUseHazard;
   logic              insertBubble;

   // Pick the EX destination (rd for R-type, rt otherwise) and note whether the
   // instruction really writes a register; writes aimed at $0 count as no write.
   always_comb begin
      exWreg      = idExCtrl[BitRegDst] ? idExRd : idExRt;
      exWritesReg = idExCtrl[BitRegWrite] && (exWreg != '0);
   end

   // A load in EX whose rt feeds the ID instruction must hold ID for one cycle.
   // Both rs and rt are compared regardless of whether the ID instruction reads
   // them: a spurious stall only costs a cycle, a missed one corrupts data.
   // Since the bubble behind the load has MemRead clear, the stall self-ends.
   always_comb begin
      loadUseHazard = idExCtrl[BitMemRead]
                   && (idExRt != '0)
                   && ((idExRt == rs_i) || (idExRt == rt_i));
      insertBubble  = loadUseHazard || flush_i;
   end

   // ID/EX takes the decoder bundle, or an all-zero bubble when ID is being
   // held back by a stall or squashed by a flush (both together: one bubble).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idExCtrl <= '0;
         idExRt   <= '0;
         idExRd   <= '0;
      end else if (insertBubble) begin
         idExCtrl <= '0;
         idExRt   <= '0;
         idExRd   <= '0;
      end else begin
         idExCtrl <= ctrl_i;
         idExRt   <= rt_i;
         idExRd   <= rd_i;
      end
   end

   // EX/MEM advances every cycle; only the memory and writeback fields move on.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exMemRegWrite <= 1'b0;
         exMemMemtoReg <= 1'b0;
         exMemMemRead  <= 1'b0;
         exMemMemWrite <= 1'b0;
         exMemWreg     <= '0;
      end else begin
         exMemRegWrite <= exWritesReg;
         exMemMemtoReg <= idExCtrl[BitMemtoReg];
         exMemMemRead  <= idExCtrl[BitMemRead];
         exMemMemWrite <= idExCtrl[BitMemWrite];
         exMemWreg     <= exWreg;
      end
   end

   // MEM/WB advances every cycle and keeps only the writeback fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         memWbRegWrite <= 1'b0;
         memWbMemtoReg <= 1'b0;
         memWbWreg     <= '0;
      end else begin
         memWbRegWrite <= exMemRegWrite;
         memWbMemtoReg <= exMemMemtoReg;
         memWbWreg     <= exMemWreg;
      end
   end

   // Drive the per-stage control fields from the stage registers.
   always_comb begin
      stall_o        = loadUseHazard;
      ex_alusrc_o    = idExCtrl[BitAluSrc];
      ex_aluop_o     = idExCtrl[BitAluOpHi:BitAluOpLo];
      ex_wreg_o      = exWreg;
      mem_memread_o  = exMemMemRead;
      mem_memwrite_o = exMemMemWrite;
      mem_regwrite_o = exMemRegWrite;
      mem_wreg_o     = exMemWreg;
      wb_regwrite_o  = memWbRegWrite;
      wb_memtoreg_o  = memWbMemtoReg;
      wb_wreg_o      = memWbWreg;
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vectors for ctrl_pipe with hand-computed expected
// outputs; a scoreboard queue decouples stimulus from the output monitor.
module tb_ctrl_pipe;

   typedef struct packed {
      logic       stall;
      logic       exAluSrc;
      logic [1:0] exAluOp;
      logic [4:0] exWreg;
      logic       memRead;
      logic       memWrite;
      logic       memRegWrite;
      logic [4:0] memWreg;
      logic       wbRegWrite;
      logic       wbMemtoReg;
      logic [4:0] wbWreg;
   } outVec_t;

   typedef struct {
      outVec_t v;
      string   name;
   } expEntry_t;

   logic       clk;
   logic       rst;
   logic [7:0] ctrl;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       flush;
   logic       stall;
   logic       exAluSrc;
   logic [1:0] exAluOp;
   logic [4:0] exWreg;
   logic       memRead;
   logic       memWrite;
   logic       memRegWrite;
   logic [4:0] memWreg;
   logic       wbRegWrite;
   logic       wbMemtoReg;
   logic [4:0] wbWreg;

   expEntry_t expQ[$];
   int        checks;
   int        failures;

   ctrl_pipe #(.CTRL_W(8), .REG_W(5)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ctrl_i         (ctrl),
      .rs_i           (rs),
      .rt_i           (rt),
      .rd_i           (rd),
      .flush_i        (flush),
      .stall_o        (stall),
      .ex_alusrc_o    (exAluSrc),
      .ex_aluop_o     (exAluOp),
      .ex_wreg_o      (exWreg),
      .mem_memread_o  (memRead),
      .mem_memwrite_o (memWrite),
      .mem_regwrite_o (memRegWrite),
      .mem_wreg_o     (memWreg),
      .wb_regwrite_o  (wbRegWrite),
      .wb_memtoreg_o  (wbMemtoReg),
      .wb_wreg_o      (wbWreg)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outVec_t makeExp(
      input logic       st,
      input logic       aSrc,
      input logic [1:0] aOp,
      input logic [4:0] exW,
      input logic       mRd,
      input logic       mWr,
      input logic       mRw,
      input logic [4:0] mW,
      input logic       wRw,
      input logic       wMtr,
      input logic [4:0] wW);
      outVec_t o;
      o = {st, aSrc, aOp, exW, mRd, mWr, mRw, mW, wRw, wMtr, wW};
      return o;
   endfunction

   // Drive one cycle of inputs just after the edge and queue what the outputs
   // must show during that same cycle.
   task automatic applyStimulus(
      input logic       r,
      input logic [7:0] c,
      input logic [4:0] s,
      input logic [4:0] t,
      input logic [4:0] d,
      input logic       f,
      input outVec_t    e,
      input string      nm);
      expEntry_t ent;
      @(posedge clk);
      #1;
      rst   = r;
      ctrl  = c;
      rs    = s;
      rt    = t;
      rd    = d;
      flush = f;
      ent.v    = e;
      ent.name = nm;
      expQ.push_back(ent);
   endtask

   task automatic checkOutput(input expEntry_t ent);
      outVec_t act;
      act = {stall, exAluSrc, exAluOp, exWreg, memRead, memWrite, memRegWrite,
             memWreg, wbRegWrite, wbMemtoReg, wbWreg};
      checks++;
      if (act !== ent.v) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", ent.name, act, ent.v);
      end
   endtask

   // Monitor: every cycle that has a queued expectation is checked mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   localparam outVec_t Zero = '0;

   initial begin
      checks   = 0;
      failures = 0;
      rst   = 1'b1;
      ctrl  = 8'h00;
      rs    = 5'd0;
      rt    = 5'd0;
      rd    = 5'd0;
      flush = 1'b0;

      // reset held two cycles with an R-type on the inputs, then released
      applyStimulus(1, 8'h87, 0, 5, 9, 0, Zero, "reset_c1");
      applyStimulus(1, 8'h87, 0, 5, 9, 0, Zero, "reset_c2");
      applyStimulus(0, 8'h87, 0, 5, 9, 0, Zero, "reset_release");
      // R-type walking EX -> MEM -> WB
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b11, 9, 0, 0, 0, 0, 0, 0, 0), "rtype_ex");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 1, 9, 0, 0, 0), "rtype_mem");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 9), "rtype_wb");
      // load-use: lw $3 then add reading rs=3
      applyStimulus(0, 8'hE8, 1, 3, 0, 0, Zero, "loaduse_idle");
      applyStimulus(0, 8'h87, 3, 4, 6, 0, makeExp(1, 1, 2'b00, 3, 0, 0, 0, 0, 0, 0, 0), "loaduse_stall");
      applyStimulus(0, 8'h87, 3, 4, 6, 0, makeExp(0, 0, 2'b00, 0, 1, 0, 1, 3, 0, 0, 0), "loaduse_bubble_ex");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b11, 6, 0, 0, 0, 0, 1, 1, 3), "loaduse_add_ex");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 1, 6, 0, 0, 0), "loaduse_add_mem");
      // lw to $0 followed by a reader of $0
      applyStimulus(0, 8'hE8, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 6), "loaduse_add_wb");
      applyStimulus(0, 8'h87, 0, 0, 7, 0, makeExp(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "r0_nostall");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b11, 7, 1, 0, 0, 0, 0, 0, 0), "r0_mem_suppressed");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 1, 7, 0, 1, 0), "r0_wb_suppressed");
      // flushed store
      applyStimulus(0, 8'h58, 2, 8, 0, 1, makeExp(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 7), "flush_issue");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, Zero, "flush_ex_bubble");
      // stall and flush in the same cycle; upstream drops the held add
      applyStimulus(0, 8'hE8, 0, 10, 0, 0, Zero, "flush_mem_clear");
      applyStimulus(0, 8'h87, 10, 11, 12, 1, makeExp(1, 1, 2'b00, 10, 0, 0, 0, 0, 0, 0, 0), "stallflush_stall");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 1, 0, 1, 10, 0, 0, 0), "stallflush_bubble");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 10), "stallflush_single");
      // load-use detected through the rt comparison, store held then issued
      applyStimulus(0, 8'hE8, 0, 4, 0, 0, Zero, "stallflush_dropped");
      applyStimulus(0, 8'h58, 1, 4, 0, 0, makeExp(1, 1, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0), "rt_match_stall");
      applyStimulus(0, 8'h58, 1, 4, 0, 0, makeExp(0, 0, 2'b00, 0, 1, 0, 1, 4, 0, 0, 0), "rt_match_bubble");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 1, 2'b00, 4, 0, 0, 0, 0, 1, 1, 4), "store_ex");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, makeExp(0, 0, 2'b00, 0, 0, 1, 0, 4, 0, 0, 0), "store_mem");
      // reset in mid-flight discards the pipeline contents
      applyStimulus(0, 8'h87, 0, 5, 9, 0, makeExp(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4), "store_wb");
      applyStimulus(1, 8'h87, 0, 5, 9, 0, makeExp(0, 0, 2'b11, 9, 0, 0, 0, 0, 0, 0, 0), "midreset_ex");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, Zero, "midreset_clear");
      applyStimulus(0, 8'h00, 0, 0, 0, 0, Zero, "midreset_idle");

      // let the monitor drain the scoreboard, bounded to a few cycles
      for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
         @(posedge clk);
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode control bundle: registers the 8-bit bundle from the decoder and carries it through the ID/EX, EX/MEM and MEM/WB pipeline stages.
- Presents per-stage control fields to EX, MEM and WB.
- Resolves the destination register in EX.
- Detects load-use hazards and inserts bubbles for stalls and flushes.
- Sits between the decoder and the datapath pipeline registers in the 5-stage CPU.

Parameters:
- CTRL_W, 8, control bundle width. Layout is fixed: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
- REG_W, 5, register specifier width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- ctrl_i  in  CTRL_W  control bundle of the instruction currently in ID
- rs_i  in  REG_W  rs field of the ID instruction
- rt_i  in  REG_W  rt field of the ID instruction
- rd_i  in  REG_W  rd field of the ID instruction
- flush_i  in  1  squash the ID instruction (taken branch or jump)
- stall_o  out  1  load-use hazard; upstream holds PC and IF/ID when high
- ex_alusrc_o  out  1  ALUSrc of the EX instruction
- ex_aluop_o  out  2  ALUOp of the EX instruction
- ex_wreg_o  out  REG_W  destination register of the EX instruction
- mem_memread_o  out  1  MemRead of the MEM instruction
- mem_memwrite_o  out  1  MemWrite of the MEM instruction
- mem_regwrite_o  out  1  RegWrite of the MEM instruction
- mem_wreg_o  out  REG_W  destination register of the MEM instruction
- wb_regwrite_o  out  1  RegWrite of the WB instruction
- wb_memtoreg_o  out  1  MemtoReg of the WB instruction
- wb_wreg_o  out  REG_W  destination register of the WB instruction

Behaviour:
- Reset: when rst_i is high at a clock edge, all stage registers clear to 0.
  - All outputs read 0 the following cycle; stall_o reads 0.
  - Reset overrides stall and flush. Instructions in flight are discarded.
- ID/EX register holds ctrl (8 bits), rt and rd.
  - Loads a bubble (all zeros) when stall_o or flush_i is high; otherwise loads ctrl_i, rt_i, rd_i.
  - Stall and flush in the same cycle: one bubble, same as either alone.
- EX destination, combinational from ID/EX: ex_wreg_o = RegDst ? rd : rt.
- EX/MEM register:
  - Loads ID/EX ctrl[7:4] and ex_wreg_o every cycle; it is never stalled.
  - Stored RegWrite = ctrl[7] AND (ex_wreg_o != 0), so writes to $0 are suppressed.
- MEM/WB register:
  - Loads RegWrite, MemtoReg and wreg from EX/MEM every cycle; it is never stalled.
  - Forward rule for RegWrite: wb_regwrite_o = mem_regwrite_o delayed one cycle.
- Latency: a bundle applied in cycle N with no stall or flush appears as follows.
  - EX outputs in cycle N+1.
  - MEM outputs in N+2.
  - WB outputs in N+3.
- stall_o is combinational:
  - stall_o = ID/EX MemRead AND (ID/EX rt != 0) AND (ID/EX rt == rs_i OR ID/EX rt == rt_i).
  - rs/rt are compared unconditionally. This is deliberately conservative: false stalls are permitted, missed stalls are not.
- stall_o lasts exactly one cycle per load: the inserted bubble has MemRead = 0.
- During a stall the decoder keeps ctrl_i/rs_i/rt_i/rd_i stable. The held instruction enters ID/EX on the next edge.
- stall_o and flush_i both high: the flush wins, and the held instruction is squashed by the upstream logic.
- Register 0: never reported as a write target with RegWrite = 1 in MEM or WB.

Test Plan:
- Reset: drive ctrl_i = 0x87 with rst_i high for 2 cycles, then release -> all outputs 0 during reset; the EX fields of 0x87 appear 1 cycle after release.
- R-type pipeline: ctrl_i = 0x87, rt = 5, rd = 9, no stall or flush.
  - Cycle +1: ex_aluop_o = 11, ex_alusrc_o = 0, ex_wreg_o = 9.
  - Cycle +2: mem_regwrite_o = 1, mem_wreg_o = 9.
  - Cycle +3: wb_regwrite_o = 1, wb_memtoreg_o = 0, wb_wreg_o = 9.
- Load-use: lw (0xE8, rt = 3), then add with rs_i = 3.
  - stall_o = 1 for exactly 1 cycle; a bubble is inserted (mem_memread_o = 0 two cycles later).
  - The add reaches EX one cycle late.
  - lw reaches WB with wb_memtoreg_o = 1, wb_wreg_o = 3.
- Write to $0: lw 0xE8 with rt = 0, then an instruction using rs_i = 0 -> stall_o stays 0; mem_regwrite_o = 0 for the lw.
- Flush: sw 0x58 in ID with flush_i = 1 -> the next cycle ID/EX is a bubble; mem_memwrite_o stays 0 two cycles later.
- Stall and flush together: set up a load-use stall and assert flush_i in the same cycle -> a single bubble; the held ID instruction never appears in EX if upstream drops it.
